// File: rtl/data_memory_responder.sv
// Single-port word memory with a fixed-latency request/response handshake.
// Optional bounds checking is enabled by defining DATA_MEMORY_BOUNDS_CHECK_EN.
module data_memory_responder #(
    parameter int OPERAND_WIDTH     = 11,
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int DEPTH             = 2048,
    parameter int WAIT_STATES       = 1
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         req_in,
    input  logic                         wr_in,
    input  logic [OPERAND_WIDTH-1:0]     address_in,
    input  logic [INSTRUCTION_WIDTH-1:0] data_in,
    output logic [INSTRUCTION_WIDTH-1:0] data_out,
    output logic                         ready_out,
    output logic                         busy_out,
    output logic                         error_out
);

    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                         state_q;
    state_t                         state_d;
    logic [3:0]                     cnt_q;
    logic [3:0]                     cnt_d;
    logic                           wr_q;
    logic [OPERAND_WIDTH-1:0]       addr_q;
    logic [INSTRUCTION_WIDTH-1:0]   wdata_q;

    logic                           accept;
    logic                           commit;
    logic                           com_wr;
    logic [OPERAND_WIDTH-1:0]       com_addr;
    logic [INSTRUCTION_WIDTH-1:0]   com_data;
    logic                           com_in_range;
    logic [IDX_W-1:0]               mem_idx;
    logic                           do_write;
    logic                           do_read;

    logic [INSTRUCTION_WIDTH-1:0]   mem [DEPTH];

    // With zero wait states the commit happens on the acceptance edge, so the
    // access fields come straight from the inputs rather than the latches.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        commit   = 1'b0;
        com_wr   = wr_q;
        com_addr = addr_q;
        com_data = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_in) begin
                    accept   = 1'b1;
                    cnt_d    = WAIT_LOAD;
                    com_wr   = wr_in;
                    com_addr = address_in;
                    com_data = data_in;
                    if (WAIT_STATES == 0) begin
                        state_d = RESPOND;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESPOND;
                    commit  = 1'b1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    localparam logic [OPERAND_WIDTH:0] DEPTH_EXT = (OPERAND_WIDTH + 1)'(DEPTH);

    assign com_in_range = ({1'b0, com_addr} < DEPTH_EXT);
    assign error_out    = (state_q == RESPOND) && ({1'b0, addr_q} >= DEPTH_EXT);
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^com_addr;
    assign com_in_range     = 1'b1;
    assign error_out        = 1'b0;
`endif

    assign mem_idx   = com_addr[IDX_W-1:0];
    // Gating with reset_in keeps a request seen during reset from landing in storage.
    assign do_write  = commit && com_wr && com_in_range && reset_in;
    assign do_read   = commit && !com_wr && com_in_range;
    assign ready_out = (state_q == RESPOND);
    assign busy_out  = (state_q != IDLE);

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_out <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= wr_in;
                addr_q  <= address_in;
                wdata_q <= data_in;
            end
            if (do_read) begin
                data_out <= mem[mem_idx];
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clock_in) begin
        if (do_write) begin
            mem[mem_idx] <= com_data;
        end
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter OPERAND_WIDTH, default 11, SHALL set the address width.
REQ-002 Parameter INSTRUCTION_WIDTH, default 16, SHALL set the data word width.
REQ-003 Parameter DEPTH, default 2048, SHALL set the number of stored words (power of two, <= 2**OPERAND_WIDTH).
REQ-004 Parameter WAIT_STATES, default 1, range 0-15, SHALL set the extra cycles between request acceptance and response.
REQ-005 clock_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset_in  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 req_in  input  1  SHALL request an access; sampled only in IDLE.
REQ-008 wr_in  input  1  SHALL select write (1) or read (0); sampled with req_in.
REQ-009 address_in  input  OPERAND_WIDTH  SHALL give the word address; sampled with req_in.
REQ-010 data_in  input  INSTRUCTION_WIDTH  SHALL give the write data; sampled with req_in.
REQ-011 data_out  output  INSTRUCTION_WIDTH  SHALL carry the read data.
REQ-012 ready_out  output  1  SHALL pulse high for one cycle when an access completes.
REQ-013 busy_out  output  1  SHALL be high in every state other than IDLE.
REQ-014 error_out  output  1  SHALL flag an out-of-range access (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, WAIT and RESPOND.
REQ-016 In IDLE with req_in=1, the block SHALL latch wr_in, address_in and data_in, and load the wait counter with WAIT_STATES.
- Next state SHALL be WAIT if WAIT_STATES>0, else RESPOND.
REQ-017 In WAIT the counter SHALL decrement each cycle; the transition to RESPOND SHALL occur on the edge where the counter reaches 0.
REQ-018 A write SHALL commit to storage on the edge entering RESPOND, using the latched address and data.
REQ-019 A read SHALL load data_out on the edge entering RESPOND.
REQ-020 RESPOND SHALL last exactly one cycle with ready_out=1, then return to IDLE.
REQ-021 Total latency from the req_in sampling edge to ready_out high SHALL be WAIT_STATES+1 cycles.
REQ-022 req_in and all other inputs SHALL be ignored while busy_out=1; no queuing.
REQ-023 req_in high during the RESPOND cycle SHALL NOT be accepted.
- The earliest next acceptance is the following IDLE cycle, so back-to-back throughput is one access per WAIT_STATES+2 cycles.
REQ-024 data_out SHALL hold its last read value across writes and idle cycles.
REQ-025 A read following a write to the same address SHALL return the newly written value.
REQ-026 Storage contents SHALL NOT be cleared by reset.

Reset
REQ-027 Asserting reset_in low SHALL immediately force: state IDLE, counter 0, data_out 0, ready_out 0, busy_out 0, error_out 0, latched request fields 0.
REQ-028 Reset asserted mid-access SHALL abort the access.
- A write not yet committed SHALL NOT be committed.
- No ready_out pulse SHALL follow the aborted access.
REQ-029 The first request SHALL be accepted on the first rising edge after reset_in deasserts.

Configuration
REQ-030 Macro DATA_MEMORY_BOUNDS_CHECK_EN SHALL control bounds checking.
- When defined, a latched address >= DEPTH SHALL suppress any write, leave data_out unchanged, and raise error_out for the same single cycle as ready_out.
- When undefined, the address SHALL wrap modulo DEPTH (low log2(DEPTH) bits used), and error_out SHALL be tied to 0.

Verification
REQ-031 WAIT_STATES=1: write 0x1234 to address 5, then read address 5 -> each ready_out 2 cycles after req_in sampled; read data_out=0x1234.
REQ-032 WAIT_STATES=0: back-to-back req_in held high -> accepted every 2 cycles; busy_out=1 only in RESPOND.
REQ-033 Write 0xBEEF to address 7, then assert reset_in low during WAIT of a write of 0x0000 to address 7 -> no ready_out; later read of address 7 returns 0xBEEF; data_out=0 right after reset.
REQ-034 Read address 3 (holding 0x00AA), then write 0x5555 to address 4 -> data_out stays 0x00AA after the write.
REQ-035 DEPTH=1024, macro defined: write 0x7777 to address 1029 -> error_out=1 with ready_out; address 5 unchanged.
- Same write with macro undefined -> address 5 reads 0x7777 and error_out stays 0.
REQ-036 req_in pulsed while busy_out=1 -> ignored; exactly one ready_out per accepted request.
